// File: rtl/core_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : core_ctrl
// Brief    : Instruction sequencer for the attention core. One start pulse
//            runs K load, Q execute, FIFO drain and optional row normalize.
//            Optional NORM phase is enabled by defining CORE_CTRL_NORM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module core_ctrl #(
    parameter int COL = 8,
    parameter int LEN = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        fifo_valid,
    output logic [19:0] inst,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_KLOAD = 3'd1;
    localparam logic [2:0] c_KWAIT = 3'd2;
    localparam logic [2:0] c_QEXEC = 3'd3;
    localparam logic [2:0] c_DRAIN = 3'd4;
    localparam logic [2:0] c_DONE  = 3'd5;
`ifdef CORE_CTRL_NORM_EN
    localparam logic [2:0] c_NORM  = 3'd6;
`endif

    localparam logic [3:0] c_COL_LAST = 4'(COL - 1);
    localparam logic [3:0] c_LEN_LAST = 4'(LEN - 1);

    logic [2:0]  r_state;
    logic [3:0]  r_cnt;
    logic [19:0] w_inst;
`ifdef CORE_CTRL_NORM_EN
    logic [1:0]  r_phase;
`endif

    // Instruction for the current state; registered so it lags the state by one cycle.
    always_comb begin
        w_inst = 20'h00000;
        case (r_state)
            c_KLOAD: w_inst = {4'h0, r_cnt, 4'h0, 8'h48};
            c_QEXEC: w_inst = {4'h0, r_cnt, 4'h0, 8'hA0};
            c_DRAIN: if (fifo_valid) w_inst = {4'h1, 4'h0, r_cnt, 8'h01};
`ifdef CORE_CTRL_NORM_EN
            c_NORM: begin
                case (r_phase)
                    2'd0:    w_inst = {4'h0, 4'h0, r_cnt, 8'h02};
                    2'd1:    w_inst = 20'h20000;
                    default: w_inst = {4'hC, 4'h0, r_cnt, 8'h01};
                endcase
            end
`endif
            default: w_inst = 20'h00000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
`ifdef CORE_CTRL_NORM_EN
            r_phase <= 2'd0;
`endif
            inst    <= 20'h00000;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            inst <= w_inst;
            busy <= (r_state != c_IDLE);
            done <= (r_state == c_DONE);
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state <= c_KLOAD;
                        r_cnt   <= 4'd0;
                    end
                end
                c_KLOAD: begin
                    if (r_cnt == c_COL_LAST) begin
                        r_state <= c_KWAIT;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                c_KWAIT: begin
                    if (r_cnt == c_COL_LAST) begin
                        r_state <= c_QEXEC;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                c_QEXEC: begin
                    if (r_cnt == c_LEN_LAST) begin
                        r_state <= c_DRAIN;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                c_DRAIN: begin
                    // The row counter only advances on cycles that actually pop.
                    if (fifo_valid) begin
                        if (r_cnt == c_LEN_LAST) begin
`ifdef CORE_CTRL_NORM_EN
                            r_state <= c_NORM;
                            r_phase <= 2'd0;
`else
                            r_state <= c_DONE;
`endif
                            r_cnt   <= 4'd0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
`ifdef CORE_CTRL_NORM_EN
                c_NORM: begin
                    if (r_phase == 2'd2) begin
                        r_phase <= 2'd0;
                        if (r_cnt == c_LEN_LAST) begin
                            r_state <= c_DONE;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end else begin
                        r_phase <= r_phase + 2'd1;
                    end
                end
`endif
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_ctrl
// Brief    : Directed self-checking bench for core_ctrl (default COL=8, LEN=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        fifo_valid = 1'b1;
    logic [19:0] inst;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [19:0] exp_inst [0:63];
    int          exp_len;

    core_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .fifo_valid (fifo_valid),
        .inst       (inst),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Expected inst words for a stall-free pass; the last entry is the DONE cycle.
    task automatic build_expected();
        int n;
        n = 0;
        for (int k = 0; k < 8; k++) begin exp_inst[n] = 20'h00048 | (20'(k) << 12); n++; end
        for (int k = 0; k < 8; k++) begin exp_inst[n] = 20'h00000; n++; end
        for (int q = 0; q < 8; q++) begin exp_inst[n] = 20'h000A0 | (20'(q) << 12); n++; end
        for (int r = 0; r < 8; r++) begin exp_inst[n] = 20'h10001 | (20'(r) << 8); n++; end
`ifdef CORE_CTRL_NORM_EN
        for (int r = 0; r < 8; r++) begin
            exp_inst[n] = 20'h00002 | (20'(r) << 8); n++;
            exp_inst[n] = 20'h20000;                 n++;
            exp_inst[n] = 20'hC0001 | (20'(r) << 8); n++;
        end
`endif
        exp_inst[n] = 20'h00000; n++;
        exp_len = n;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one pass and compares every inst/busy/done sample.
    // stall_after: expected index after which fifo_valid drops for stall_len cycles.
    // abort_at: expected index whose producing edge sees reset instead.
    task automatic run_pass(input int stall_after, input int stall_len, input int abort_at,
                            input int glitch_at, input bit glitch_done);
        int idx;
        int stall_left;
        int steps;
        int dones;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (inst !== 20'h0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL start_latency: inst=%h busy=%b, required inst=00000 busy=0", inst, busy);
        end
        idx = 0; stall_left = 0; steps = 0; dones = 0;
        while (idx < exp_len && steps < 200) begin
            steps++;
            fifo_valid = (stall_left > 0) ? 1'b0 : 1'b1;
            start = (idx == glitch_at) || (glitch_done && idx == exp_len - 1);
            if (idx == abort_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                start = 1'b0;
                n_cmp++;
                if (inst !== 20'h0 || busy !== 1'b0 || done !== 1'b0) begin
                    n_bad++;
                    $display("FAIL abort_reset: inst=%h busy=%b done=%b, required 00000/0/0", inst, busy, done);
                end
                for (int i = 0; i < 70; i++) begin
                    tick();
                    n_cmp++;
                    if (done !== 1'b0 || inst !== 20'h0) begin
                        n_bad++;
                        $display("FAIL abort_idle: cycle %0d inst=%h done=%b, required 00000/0", i, inst, done);
                    end
                end
                return;
            end
            tick();
            start = 1'b0;
            if (done === 1'b1) dones++;
            if (stall_left > 0) begin
                stall_left--;
                n_cmp++;
                if (inst !== 20'h0 || busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL drain_stall: inst=%h busy=%b, required 00000/1", inst, busy);
                end
            end else begin
                n_cmp++;
                if (inst !== exp_inst[idx] || busy !== 1'b1 || done !== (idx == exp_len - 1)) begin
                    n_bad++;
                    $display("FAIL seq[%0d]: inst=%h busy=%b done=%b, required inst=%h busy=1 done=%b",
                             idx, inst, busy, done, exp_inst[idx], (idx == exp_len - 1));
                end
                if (idx == stall_after) stall_left = stall_len;
                idx++;
            end
        end
        n_cmp++;
        if (idx != exp_len) begin
            n_bad++;
            $display("FAIL pass_timeout: reached index %0d, required %0d", idx, exp_len);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done === 1'b1) dones++;
            n_cmp++;
            if (inst !== 20'h0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL post_idle: cycle %0d inst=%h busy=%b, required 00000/0", i, inst, busy);
            end
        end
        n_cmp++;
        if (dones != 1) begin
            n_bad++;
            $display("FAIL done_count: got %0d done pulses, required 1", dones);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (inst !== 20'h0 || busy !== 1'b0 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_state: inst=%h busy=%b done=%b, required 00000/0/0", inst, busy, done);
            end
        end
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (inst !== 20'h0 || busy !== 1'b0 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_state: cycle %0d inst=%h busy=%b done=%b, required 00000/0/0", i, inst, busy, done);
            end
        end
    endtask

    task automatic test_full_pass();
        run_pass(-1, 0, -1, -1, 1'b0);
    endtask

    task automatic test_drain_stall();
        // Index 26 is the third pop (PSUM address 2); the next pop must use address 3.
        run_pass(26, 5, -1, -1, 1'b0);
    endtask

    task automatic test_reset_mid_pass();
`ifdef CORE_CTRL_NORM_EN
        run_pass(-1, 0, 36, -1, 1'b0);
`else
        run_pass(-1, 0, 25, -1, 1'b0);
`endif
        run_pass(-1, 0, -1, -1, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_pass(-1, 0, -1, 18, 1'b1);
    endtask

    initial begin
        build_expected();
        test_reset();
        test_full_pass();
        test_drain_stall();
        test_reset_mid_pass();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
